// File: rtl/fb_pkg.sv
// Shared framebuffer constants and the grant encoding used by the arbiter.
package fb_pkg;

   localparam int          RAM_WIDTH     = 24;
   localparam int          MEM_ADDR_BITS = 20;
   localparam logic [31:0] FB_BASE       = 32'h9000_0000;

   // Who owns the RAM port in the current cycle.
   typedef enum logic [1:0] {
      GNT_IDLE = 2'd0,
      GNT_VID  = 2'd1,
      GNT_CPU  = 2'd2
   } gnt_e;

endpackage

// File: rtl/fb_return_fifo.sv
// Read-return FIFO with a registered head entry and an occupancy output.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module fb_return_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_head,
   output logic                       o_valid,
   output logic [$clog2(DEPTH):0]     o_occ
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_occ;
   logic [WIDTH-1:0] r_head;
   logic             w_do_pop;
   logic [AW-1:0]    w_rd_nxt;

   assign w_do_pop = i_pop & (r_occ != '0);
   assign w_rd_nxt = r_rd_ptr + AW'(w_do_pop);

   // pointers and occupancy; push and pop together leave occupancy alone
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (i_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop) r_rd_ptr <= w_rd_nxt;
         case ({i_push, w_do_pop})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   // storage; a push arriving during reset is dropped
   always_ff @(posedge clk) begin
      if (!rst && i_push) r_mem[r_wr_ptr] <= i_data;
   end

   // head register: bypass a push into an empty slot, otherwise advance on pop
   always_ff @(posedge clk) begin
      if (rst)                                 r_head <= '0;
      else if (i_push && r_wr_ptr == w_rd_nxt) r_head <= i_data;
      else if (w_do_pop)                       r_head <= r_mem[w_rd_nxt];
   end

   assign o_head  = r_head;
   assign o_valid = (r_occ != '0);
   assign o_occ   = r_occ;

endmodule

// File: rtl/framebuffer_arbiter.sv
// Single-port framebuffer arbiter: video reads win, a streak counter bounds
// CPU write starvation, and read data returns through a credit-checked FIFO.
module framebuffer_arbiter
   import fb_pkg::*;
#(
   parameter int RAM_WIDTH     = fb_pkg::RAM_WIDTH,
   parameter int MEM_ADDR_BITS = fb_pkg::MEM_ADDR_BITS,
   parameter int FIFO_DEPTH    = 4,
   parameter int MAX_STREAK    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              i_vid_addr,
   input  logic                     i_vid_addr_valid,
   output logic                     o_vid_addr_rdy,
   output logic [RAM_WIDTH-1:0]     o_vid_data,
   output logic                     o_vid_data_valid,
   input  logic                     i_vid_data_rdy,
   input  logic [31:0]              i_cpu_addr,
   input  logic [RAM_WIDTH-1:0]     i_cpu_wdata,
   input  logic                     i_cpu_valid,
   output logic                     o_cpu_rdy,
   output logic [MEM_ADDR_BITS-1:0] o_mem_addr,
   output logic                     o_mem_en,
   output logic                     o_mem_we,
   output logic [RAM_WIDTH-1:0]     o_mem_wdata,
   input  logic [RAM_WIDTH-1:0]     i_mem_rdata
);

   localparam int            OW         = $clog2(FIFO_DEPTH) + 1;
   localparam int            SW         = $clog2(MAX_STREAK + 1);
   localparam logic [OW-1:0] DEPTH_L    = OW'(FIFO_DEPTH);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

   logic [OW-1:0] w_occ;
   logic          r_inflight;
   logic [SW-1:0] r_streak;
   logic          w_credit_ok;
   logic          w_vid_ok;
   logic          w_pop;
   gnt_e          w_gnt;
   logic          w_unused;

   // Address bits above the RAM index carry the framebuffer base and are dropped.
   assign w_unused = ^{i_vid_addr[31:MEM_ADDR_BITS], i_cpu_addr[31:MEM_ADDR_BITS]};

   // Credit uses registered state only, so a same-cycle pop never frees a slot.
   assign w_credit_ok = (w_occ + OW'(r_inflight)) < DEPTH_L;
   assign w_vid_ok    = i_vid_addr_valid & w_credit_ok;

   // grant select: CPU on an unusable video slot or when the streak is spent
   always_comb begin
      w_gnt = GNT_IDLE;
      if (rst)
         w_gnt = GNT_IDLE;
      else if (i_cpu_valid && (!w_vid_ok || r_streak == STREAK_MAX))
         w_gnt = GNT_CPU;
      else if (w_vid_ok)
         w_gnt = GNT_VID;
   end

   // drive the RAM port and handshakes from the grant
   always_comb begin
      o_mem_en       = 1'b0;
      o_mem_we       = 1'b0;
      o_mem_addr     = i_vid_addr[MEM_ADDR_BITS-1:0];
      o_mem_wdata    = i_cpu_wdata;
      o_vid_addr_rdy = 1'b0;
      o_cpu_rdy      = 1'b0;
      case (w_gnt)
         GNT_CPU: begin
            o_mem_en   = 1'b1;
            o_mem_we   = 1'b1;
            o_mem_addr = i_cpu_addr[MEM_ADDR_BITS-1:0];
            o_cpu_rdy  = 1'b1;
         end
         GNT_VID: begin
            o_mem_en       = 1'b1;
            o_vid_addr_rdy = 1'b1;
         end
         default: ;
      endcase
   end

   // streak of video grants while a CPU write waits, saturating
   always_ff @(posedge clk) begin
      if (rst || !i_cpu_valid || w_gnt == GNT_CPU)
         r_streak <= '0;
      else if (w_gnt == GNT_VID && r_streak != STREAK_MAX)
         r_streak <= r_streak + 1'b1;
   end

   // RAM read data is due the cycle after a video grant
   always_ff @(posedge clk) begin
      if (rst) r_inflight <= 1'b0;
      else     r_inflight <= (w_gnt == GNT_VID);
   end

   assign w_pop = o_vid_data_valid & i_vid_data_rdy;

   fb_return_fifo #(
      .WIDTH (RAM_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_inflight),
      .i_data  (i_mem_rdata),
      .i_pop   (w_pop),
      .o_head  (o_vid_data),
      .o_valid (o_vid_data_valid),
      .o_occ   (w_occ)
   );

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter with a simple registered RAM model.
module tb_framebuffer_arbiter;

   localparam logic [31:0] FB = 32'h9000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_vid_addr;
   logic        i_vid_addr_valid;
   logic        o_vid_addr_rdy;
   logic [23:0] o_vid_data;
   logic        o_vid_data_valid;
   logic        i_vid_data_rdy;
   logic [31:0] i_cpu_addr;
   logic [23:0] i_cpu_wdata;
   logic        i_cpu_valid;
   logic        o_cpu_rdy;
   logic [19:0] o_mem_addr;
   logic        o_mem_en;
   logic        o_mem_we;
   logic [23:0] o_mem_wdata;
   logic [23:0] i_mem_rdata;

   int n_chk  = 0;
   int n_fail = 0;
   int g;

   always #5 clk = ~clk;

   framebuffer_arbiter dut (
      .clk              (clk),
      .rst              (rst),
      .i_vid_addr       (i_vid_addr),
      .i_vid_addr_valid (i_vid_addr_valid),
      .o_vid_addr_rdy   (o_vid_addr_rdy),
      .o_vid_data       (o_vid_data),
      .o_vid_data_valid (o_vid_data_valid),
      .i_vid_data_rdy   (i_vid_data_rdy),
      .i_cpu_addr       (i_cpu_addr),
      .i_cpu_wdata      (i_cpu_wdata),
      .i_cpu_valid      (i_cpu_valid),
      .o_cpu_rdy        (o_cpu_rdy),
      .o_mem_addr       (o_mem_addr),
      .o_mem_en         (o_mem_en),
      .o_mem_we         (o_mem_we),
      .o_mem_wdata      (o_mem_wdata),
      .i_mem_rdata      (i_mem_rdata)
   );

   // RAM model: unwritten words read back as their own index
   logic [23:0] ram     [256];
   logic        wr_flag [256] = '{default: 1'b0};
   always @(posedge clk) begin
      if (o_mem_en) begin
         if (o_mem_we) begin
            ram[o_mem_addr[7:0]]     <= o_mem_wdata;
            wr_flag[o_mem_addr[7:0]] <= 1'b1;
         end else begin
            i_mem_rdata <= wr_flag[o_mem_addr[7:0]] ? ram[o_mem_addr[7:0]]
                                                    : {16'h0, o_mem_addr[7:0]};
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      i_vid_addr = FB; i_vid_addr_valid = 1'b0; i_vid_data_rdy = 1'b1;
      i_cpu_addr = FB; i_cpu_wdata = '0; i_cpu_valid = 1'b0;
      repeat (2) @(negedge clk);

      // reset state, with both requesters asking
      i_vid_addr_valid = 1'b1; i_cpu_valid = 1'b1;
      #1;
      chk("rst vid_rdy", o_vid_addr_rdy, 0);
      chk("rst cpu_rdy", o_cpu_rdy, 0);
      chk("rst mem_en", o_mem_en, 0);
      chk("rst mem_we", o_mem_we, 0);
      chk("rst dvalid", o_vid_data_valid, 0);
      chk("rst vid_data", o_vid_data, 0);
      chk("rst occ", dut.w_occ, 0);
      @(negedge clk);
      rst = 1'b0; i_vid_addr_valid = 1'b0; i_cpu_valid = 1'b0;

      // video-only streaming, one read per cycle, data two cycles behind
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         i_vid_addr_valid = (k < 8);
         i_vid_addr = FB + k;
         #1;
         chk("t1 vgnt", o_vid_addr_rdy, (k < 8));
         if (k < 8) chk("t1 addr", o_mem_addr, k);
         if (k < 8) chk("t1 we", o_mem_we, 0);
         chk("t1 dvalid", o_vid_data_valid, (k >= 2 && k < 10));
         if (k >= 2 && k < 10) chk("t1 data", o_vid_data, k - 2);
      end

      // starvation bound: eight video grants, then the CPU write
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         i_vid_addr_valid = 1'b1; i_vid_addr = FB + 32'h20;
         i_cpu_valid = (k <= 8); i_cpu_addr = FB + 32'h10; i_cpu_wdata = 24'hABCDEF;
         #1;
         chk("t2 vgnt", o_vid_addr_rdy, (k != 8));
         chk("t2 cgnt", o_cpu_rdy, (k == 8));
         if (k == 8) begin
            chk("t2 we", o_mem_we, 1);
            chk("t2 en", o_mem_en, 1);
            chk("t2 addr", o_mem_addr, 32'h10);
            chk("t2 wdata", o_mem_wdata, 32'hABCDEF);
         end
      end
      for (int d = 0; d < 4; d++) begin
         @(negedge clk);
         i_vid_addr_valid = 1'b0; i_cpu_valid = 1'b0;
         #1;
         if (d == 1) chk("t2 last data", o_vid_data, 32'h20);
      end
      chk("t2 drained", o_vid_data_valid, 0);
      chk("t2 occ", dut.w_occ, 0);

      // backpressure: four credits, then stall, then drain in order
      g = 0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         i_vid_addr_valid = 1'b1; i_vid_addr = FB + g;
         i_vid_data_rdy = (k >= 6);
         #1;
         chk("t3 vgnt", o_vid_addr_rdy, (k < 4 || k >= 7));
         if (o_vid_addr_rdy) g++;
         if (k == 4) chk("t3 occ3", dut.w_occ, 3);
         if (k == 5) chk("t3 occ4", dut.w_occ, 4);
         if (k == 5) chk("t3 head held", o_vid_data, 0);
         if (k >= 6) chk("t3 dvalid", o_vid_data_valid, 1);
         if (k >= 6) chk("t3 data", o_vid_data, k - 6);
      end
      for (int d = 0; d < 8; d++) begin
         @(negedge clk);
         i_vid_addr_valid = 1'b0; i_vid_data_rdy = 1'b1;
      end
      #1;
      chk("t3 drained", o_vid_data_valid, 0);
      chk("t3 occ", dut.w_occ, 0);

      // CPU fills idle slots back to back, then read back
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         i_vid_addr_valid = 1'b0;
         i_cpu_valid = 1'b1; i_cpu_addr = FB + 32'h40 + k; i_cpu_wdata = 24'((k + 1) * 32'h111111);
         #1;
         chk("t4 cgnt", o_cpu_rdy, 1);
         chk("t4 we", o_mem_we, 1);
         chk("t4 addr", o_mem_addr, 32'h40 + k);
         chk("t4 streak", dut.r_streak, 0);
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         i_cpu_valid = 1'b0;
         i_vid_addr_valid = (k < 3); i_vid_addr = FB + 32'h40 + k;
         #1;
         if (k == 0) chk("t4 streak after", dut.r_streak, 0);
         if (k < 3) chk("t4 vgnt", o_vid_addr_rdy, 1);
         if (k >= 2 && k < 5) chk("t4 dvalid", o_vid_data_valid, 1);
         if (k >= 2 && k < 5) chk("t4 rdback", o_vid_data, (k - 1) * 32'h111111);
      end

      // reset in the cycle after a video grant discards the read
      repeat (2) @(negedge clk);
      i_vid_addr_valid = 1'b1; i_vid_addr = FB + 32'h77;
      #1;
      chk("t5 vgnt", o_vid_addr_rdy, 1);
      @(negedge clk);
      rst = 1'b1; i_cpu_valid = 1'b1;
      #1;
      chk("t5 rst vgnt", o_vid_addr_rdy, 0);
      chk("t5 rst cgnt", o_cpu_rdy, 0);
      chk("t5 rst en", o_mem_en, 0);
      @(negedge clk);
      rst = 1'b0; i_vid_addr_valid = 1'b0; i_cpu_valid = 1'b0;
      for (int d = 0; d < 3; d++) begin
         #1;
         chk("t5 dvalid", o_vid_data_valid, 0);
         chk("t5 occ", dut.w_occ, 0);
         chk("t5 vid_data", o_vid_data, 0);
         @(negedge clk);
      end
      for (int k = 0; k < 4; k++) begin
         i_vid_addr_valid = (k == 0); i_vid_addr = FB + 32'h5;
         #1;
         if (k == 0) chk("t5 regrant", o_vid_addr_rdy, 1);
         if (k == 2) chk("t5 dvalid2", o_vid_data_valid, 1);
         if (k == 2) chk("t5 data", o_vid_data, 32'h5);
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/framebuffer_arbiter.md
# framebuffer_arbiter

Shares the single-port framebuffer RAM between two requesters: the video controller, which reads pixels, and the CPU MMIO path, which writes pixels. Video reads have priority. A starvation counter guarantees the CPU a write slot after a bounded run of video grants. Read data returns to the video controller through a small credit-managed FIFO, so RAM read data is never dropped while the sink stalls.

## Interface
Parameters:
- `RAM_WIDTH`, 24, pixel word width.
- `MEM_ADDR_BITS`, 20, RAM index width; request address bits above this are ignored, which strips the 0x9000_0000 base.
- `FIFO_DEPTH`, 4, read-return FIFO entries; must be a power of 2 and ≥ 2.
- `MAX_STREAK`, 8, maximum consecutive video grants while a CPU write is pending.

Ports:
- `clk` in 1: pixel clock. Reset is `rst`, synchronous, active-high; clock is `clk`.
- `rst` in 1: synchronous active-high reset.
- `vid_addr` in 32: video read address.
- `vid_addr_valid` in 1: video read request.
- `vid_addr_rdy` out 1: video request granted this cycle.
- `vid_data` out RAM_WIDTH: read data to the video controller.
- `vid_data_valid` out 1: `vid_data` is valid.
- `vid_data_rdy` in 1: the video controller accepts `vid_data`.
- `cpu_addr` in 32: CPU write address.
- `cpu_wdata` in RAM_WIDTH: CPU write data.
- `cpu_valid` in 1: CPU write request.
- `cpu_rdy` out 1: CPU write granted this cycle.
- `mem_addr` out MEM_ADDR_BITS: RAM index.
- `mem_en` out 1: RAM access strobe.
- `mem_we` out 1: RAM write enable.
- `mem_wdata` out RAM_WIDTH: RAM write data.
- `mem_rdata` in RAM_WIDTH: RAM read data, valid the cycle after a read strobe.

## Operation
Bookkeeping:
- `occ` is the number of entries in the FIFO, 0..FIFO_DEPTH.
- `inflight` is 1 in the cycle after a read strobe, otherwise 0.
- `credit_ok = (occ + inflight) < FIFO_DEPTH`. This uses registered values only; a pop in the same cycle is not counted.
- `vid_ok = vid_addr_valid & credit_ok`.

Grant, combinational and evaluated every cycle (at most one grant per cycle):
- CPU is granted when `cpu_valid & (!vid_ok | streak == MAX_STREAK)`.
- Otherwise video is granted when `vid_ok`.
- Otherwise the cycle is idle.

Grant effects:
- A CPU grant drives `mem_en=1`, `mem_we=1`, `mem_addr=cpu_addr[MEM_ADDR_BITS-1:0]`, `mem_wdata=cpu_wdata`, and `cpu_rdy=1`.
- A video grant drives `mem_en=1`, `mem_we=0`, `mem_addr=vid_addr[MEM_ADDR_BITS-1:0]`, and `vid_addr_rdy=1`. It sets `inflight` for the next cycle.
- On an idle cycle, `mem_en=0` and `mem_we=0`.

Streak counter:
- Clears to 0 on a CPU grant, or on any cycle with `!cpu_valid`.
- Otherwise increments on each video grant, saturating at MAX_STREAK.

Return FIFO:
- When `inflight=1`, `mem_rdata` is pushed unconditionally. Overflow is impossible by construction of the credit check.
- A pop occurs on `vid_data_valid & vid_data_rdy`.
- A simultaneous push and pop leaves `occ` unchanged.
- `vid_data` is the head entry; `vid_data_valid = (occ != 0)`.

Reset, including mid-operation:
- Clears `occ`, the FIFO pointers, `inflight` and `streak`. Any in-flight read data is discarded.
- While `rst=1`, all grants are forced to 0.

## Timing
Reset values:
- `vid_addr_rdy`, `cpu_rdy`, `vid_data_valid`, `mem_en`, `mem_we` are 0.
- `mem_addr`, `mem_wdata` are don't-care.
- `vid_data` is 0 (the FIFO head register is cleared).

Latency and throughput:
- A video grant in cycle N gives `mem_rdata` at N+1, pushed at the end of N+1, and `vid_data_valid` from N+2.
- Read-to-data latency is 2 cycles.
- With `FIFO_DEPTH` ≥ 4 and the sink always ready, the video path sustains one read per cycle.

Handshakes:
- `vid_addr_rdy` and `cpu_rdy` are combinational and may depend on their own valid inputs.
- Requesters must hold address and data stable until granted.
- A write is complete at the grant edge.

Ordering:
- Video data returns in request order.
- A CPU write granted in cycle N is visible to a video read granted in N+1 or later.

## Structure
- A shared package `fb_pkg` holds `RAM_WIDTH`, `MEM_ADDR_BITS` and the framebuffer base constant 32'h9000_0000.
- Sub-module `fb_return_fifo`: a synchronous FIFO with depth parameter, `occ` output and registered head. The grant logic, streak counter and `inflight` flop stay in the top module.

## Test plan
- **Video-only streaming.** `vid_addr_valid` held high, addresses 0x9000_0000..0x9000_0007, `vid_data_rdy=1`; RAM preloaded with data = index. Expect 8 grants in 8 consecutive cycles, `vid_data` = 0..7 starting 2 cycles after the first grant, no bubbles.
- **Starvation bound.** Video always valid with the sink ready; `cpu_valid` asserted with `cpu_addr=0x9000_0010`, `cpu_wdata=0xABCDEF`. Expect `cpu_rdy` exactly after 8 video grants, `mem_we=1`, `mem_addr=0x00010`.
- **Backpressure.** `vid_data_rdy=0` with video valid. Expect exactly 4 grants, then `vid_addr_rdy=0`, `occ=4`. Release the sink: data 0..3 drains in order and grants resume.
- **CPU fills idle slots.** `vid_addr_valid=0`, 3 back-to-back CPU writes. Expect 3 consecutive `cpu_rdy`, streak stays 0. A subsequent read of the same addresses returns the written values.
- **Reset mid-read.** Assert `rst` in the cycle after a video grant. Expect `vid_data_valid=0` after reset, `occ=0`, and the discarded `mem_rdata` never appears on `vid_data`.
